generador_indice_mascara: RTL
=============================

Name: generador_indice_mascara

Overview:
- Parametrised mask-index sequencer for the filter datapath.
- Latches a programmable square mask size K and mode, then sweeps all K*K mask coefficient positions.
- Each position is emitted as a linear index plus row/column over a valid/ready handshake to the coefficient memory and MAC stage.
- Mode selects forward scan (correlation) or reversed/flipped scan (convolution).
- Supports abort and config error flagging.

Parameters:
- BITS_MASCARA, 4: width of mask side K; legal K = 1..2^BITS_MASCARA-1.
- BITS_INDICE_MASCARA, 10: width of linear index. Must be >= 2*BITS_MASCARA; elaboration fails otherwise.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cargar_config  in  1  load tamano_mascara_in/modo_in; honoured only in REPOSO.
- tamano_mascara_in  in  BITS_MASCARA  mask side K.
- modo_in  in  1  0 = forward scan, 1 = reversed scan.
- inicio  in  1  start sweep; honoured only in REPOSO.
- abortar  in  1  synchronous abort of a sweep.
- listo_sig  in  1  downstream ready.
- indice_valido  out  1  index outputs valid.
- indice  out  BITS_INDICE_MASCARA  linear index fila*K+columna.
- fila  out  BITS_MASCARA  row of current position.
- columna  out  BITS_MASCARA  column of current position.
- fin_fila  out  1  current element is the last of its row in scan order.
- ultimo  out  1  current element is the last of the sweep.
- ocupado  out  1  high in BARRIDO and FIN.
- terminado  out  1  one-cycle pulse after the last element is accepted.
- error_config  out  1  sticky config-error flag.

Behaviour:
- Reset (reset=0, async):
  - State REPOSO; stored K=1, stored modo=0.
  - All outputs 0.
- Config:
  - cargar_config in REPOSO with tamano_mascara_in!=0 stores K and modo, and clears error_config next cycle.
  - tamano_mascara_in=0 leaves stored values unchanged and sets error_config=1. It stays set until the next valid load.
  - cargar_config outside REPOSO is ignored, with no error.
  - If cargar_config and inicio arrive in the same REPOSO cycle, the config loads first and the sweep uses the new values.
- FSM, REPOSO -> BARRIDO:
  - inicio at edge n loads the first element.
  - indice_valido=1 from cycle n+1, giving 1-cycle latency.
  - Forward first element: fila=0, columna=0, indice=0.
  - Reversed first element: fila=K-1, columna=K-1, indice=K*K-1.
- FSM, BARRIDO:
  - Advance only when indice_valido && listo_sig.
  - While listo_sig=0, all index outputs hold stable.
  - Forward order is row-major ascending: columna increments; at K-1 it wraps to 0 and fila increments. indice increments by 1.
  - Reversed order is the exact reverse: columna decrements; at 0 it wraps to K-1 and fila decrements. indice decrements by 1.
  - indice is computed by counter only; no multiplier.
  - fin_fila=1 when columna==K-1 (forward) or columna==0 (reversed).
  - ultimo=1 on the final element.
  - Full throughput: one element per cycle when listo_sig stays high.
- FSM, BARRIDO -> FIN: on acceptance of the ultimo element, indice_valido=0 next cycle.
- FSM, FIN: terminado=1 for exactly one cycle, then REPOSO. ocupado drops in the cycle after FIN.
- abortar in BARRIDO or FIN:
  - Next cycle: REPOSO, indice_valido=0, no terminado pulse.
  - abortar takes priority over a simultaneous handshake.
  - abortar in REPOSO has no effect.
- inicio in BARRIDO or FIN is ignored.
- K=1: single element with indice=0, fila=columna=0, fin_fila=ultimo=1.
- Maximum K (15 at defaults): last forward indice = 224; no overflow.
- Reset asserted mid-sweep: immediate return to reset values, and stored config reverts to K=1, modo=0.

Test Plan:
- After reset, load K=3 modo=0, pulse inicio, hold listo_sig=1:
  - Indices 0..8 appear on consecutive cycles from 1 cycle after inicio.
  - fin_fila=1 at indices 2, 5 and 8; ultimo=1 at 8.
  - terminado pulses once, in the cycle after index 8.
- Load K=3 modo=1, run the sweep: sequence is 8,7,...,0 with (fila,columna) from (2,2) to (0,0), and fin_fila=1 at indices 6, 3 and 0.
- K=4 forward with listo_sig toggled 1,0,0,1,...:
  - Outputs are held while listo_sig=0.
  - All 16 indices 0..15 appear once each, none dropped or duplicated.
- Config error and priority:
  - Load tamano_mascara_in=0: error_config=1 and the stored K is unchanged (the next sweep uses the old K).
  - A valid load of K=2 clears error_config.
  - cargar_config K=5 during a sweep is ignored.
- abortar at index 4 of a K=3 sweep: indice_valido=0 next cycle, no terminado pulse, ocupado=0, and a new inicio restarts at index 0.
- K=1 sweep: exactly one element (indice=0, ultimo=1, fin_fila=1) followed by a terminado pulse. Also assert reset=0 mid-sweep of K=15 and confirm all outputs are 0 immediately.

Source files
------------

// File: rtl/generador_indice_mascara.sv
// generador_indice_mascara: sweeps all K*K positions of a square filter mask (forward or flipped order).
// Latency: first element valid 1 cycle after inicio; one element per cycle with listo_sig held high.
// Backpressure: outputs hold while listo_sig is low; advances only on indice_valido && listo_sig.
module generador_indice_mascara #(
  parameter int BITS_MASCARA        = 4,
  parameter int BITS_INDICE_MASCARA = 10
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cargar_config,
  input  logic [BITS_MASCARA-1:0]        tamano_mascara_in,
  input  logic                           modo_in,
  input  logic                           inicio,
  input  logic                           abortar,
  input  logic                           listo_sig,
  output logic                           indice_valido,
  output logic [BITS_INDICE_MASCARA-1:0] indice,
  output logic [BITS_MASCARA-1:0]        fila,
  output logic [BITS_MASCARA-1:0]        columna,
  output logic                           fin_fila,
  output logic                           ultimo,
  output logic                           ocupado,
  output logic                           terminado,
  output logic                           error_config
);

  localparam int BM = BITS_MASCARA;
  localparam int BI = BITS_INDICE_MASCARA;

  // The linear index must be able to hold K*K-1 for the largest K.
  generate
    if (BI < 2 * BM) begin : g_chk_anchura
      $error("BITS_INDICE_MASCARA must be >= 2*BITS_MASCARA");
    end
  endgenerate

  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    BARRIDO = 2'd1,
    FIN     = 2'd2
  } estado_t;

  estado_t       r_estado;
  logic [BM-1:0] r_k;
  logic          r_modo;
  logic [BM-1:0] r_fila;
  logic [BM-1:0] r_columna;
  logic [BI-1:0] r_indice;
  logic          r_valido;
  logic          r_fin_fila;
  logic          r_ultimo;
  logic          r_ocupado;
  logic          r_terminado;
  logic          r_error;

  // Start-of-sweep values: a same-cycle valid load overrides the stored config.
  logic          w_cfg_ok;
  logic [BM-1:0] w_k_ini;
  logic          w_modo_ini;
  logic [BM-1:0] w_km1_ini;
  logic [BI-1:0] w_k_ext;
  logic [BI-1:0] w_ult_ini;
  logic          w_uno_ini;

  assign w_cfg_ok   = cargar_config && (tamano_mascara_in != '0);
  assign w_k_ini    = w_cfg_ok ? tamano_mascara_in : r_k;
  assign w_modo_ini = w_cfg_ok ? modo_in : r_modo;
  assign w_km1_ini  = w_k_ini - BM'(1);
  assign w_k_ext    = BI'(w_k_ini);
  // Only the reversed start index needs K*K-1; stepping afterwards is pure counting.
  assign w_ult_ini  = (w_k_ext * w_k_ext) - BI'(1);
  assign w_uno_ini  = (w_k_ini == BM'(1));

  // Next scan position; K and mode are frozen while a sweep is running.
  logic [BM-1:0] w_km1;
  logic [BM-1:0] w_fila_sig;
  logic [BM-1:0] w_col_sig;
  logic [BI-1:0] w_idx_sig;
  logic          w_fin_sig;
  logic          w_ult_sig;

  assign w_km1 = r_k - BM'(1);

  // Compute the successor of the current element in forward or reversed order.
  always_comb begin
    w_fila_sig = r_fila;
    w_col_sig  = r_columna;
    w_idx_sig  = r_indice;
    w_fin_sig  = 1'b0;
    w_ult_sig  = 1'b0;
    if (!r_modo) begin
      if (r_columna == w_km1) begin
        w_col_sig  = '0;
        w_fila_sig = r_fila + BM'(1);
      end else begin
        w_col_sig  = r_columna + BM'(1);
      end
      w_idx_sig = r_indice + BI'(1);
      w_fin_sig = (w_col_sig == w_km1);
      w_ult_sig = (w_fila_sig == w_km1) && (w_col_sig == w_km1);
    end else begin
      if (r_columna == '0) begin
        w_col_sig  = w_km1;
        w_fila_sig = r_fila - BM'(1);
      end else begin
        w_col_sig  = r_columna - BM'(1);
      end
      w_idx_sig = r_indice - BI'(1);
      w_fin_sig = (w_col_sig == '0);
      w_ult_sig = (w_fila_sig == '0) && (w_col_sig == '0);
    end
  end

  // Control FSM with registered outputs and config storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_estado    <= REPOSO;
      r_k         <= BM'(1);
      r_modo      <= 1'b0;
      r_fila      <= '0;
      r_columna   <= '0;
      r_indice    <= '0;
      r_valido    <= 1'b0;
      r_fin_fila  <= 1'b0;
      r_ultimo    <= 1'b0;
      r_ocupado   <= 1'b0;
      r_terminado <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_terminado <= 1'b0;
      case (r_estado)
        REPOSO: begin
          if (cargar_config) begin
            if (w_cfg_ok) begin
              r_k     <= tamano_mascara_in;
              r_modo  <= modo_in;
              r_error <= 1'b0;
            end else begin
              r_error <= 1'b1;
            end
          end
          if (inicio) begin
            r_estado   <= BARRIDO;
            r_ocupado  <= 1'b1;
            r_valido   <= 1'b1;
            r_fin_fila <= w_uno_ini;
            r_ultimo   <= w_uno_ini;
            if (w_modo_ini) begin
              r_fila    <= w_km1_ini;
              r_columna <= w_km1_ini;
              r_indice  <= w_ult_ini;
            end else begin
              r_fila    <= '0;
              r_columna <= '0;
              r_indice  <= '0;
            end
          end
        end
        BARRIDO: begin
          if (abortar) begin
            r_estado   <= REPOSO;
            r_ocupado  <= 1'b0;
            r_valido   <= 1'b0;
            r_fin_fila <= 1'b0;
            r_ultimo   <= 1'b0;
          end else if (r_valido && listo_sig) begin
            if (r_ultimo) begin
              r_estado    <= FIN;
              r_valido    <= 1'b0;
              r_fin_fila  <= 1'b0;
              r_ultimo    <= 1'b0;
              r_terminado <= 1'b1;
            end else begin
              r_fila     <= w_fila_sig;
              r_columna  <= w_col_sig;
              r_indice   <= w_idx_sig;
              r_fin_fila <= w_fin_sig;
              r_ultimo   <= w_ult_sig;
            end
          end
        end
        FIN: begin
          // An abort here has the same effect as the normal exit.
          r_estado  <= REPOSO;
          r_ocupado <= 1'b0;
        end
        default: begin
          r_estado  <= REPOSO;
          r_ocupado <= 1'b0;
          r_valido  <= 1'b0;
        end
      endcase
    end
  end

  assign indice_valido = r_valido;
  assign indice        = r_indice;
  assign fila          = r_fila;
  assign columna       = r_columna;
  assign fin_fila      = r_fin_fila;
  assign ultimo        = r_ultimo;
  assign ocupado       = r_ocupado;
  assign terminado     = r_terminado;
  assign error_config  = r_error;

endmodule
